fetch_inst_queue: RTL and testbench

FETCH_INST_QUEUE -- requirements
Module: fetch_inst_queue

---
 rtl/fetch_inst_queue.sv | 96 +++++++++
 tb/tb_fetch_inst_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue: a circular buffer that takes up to WIDTH
// compacted entries per cycle from fetch and presents the WIDTH oldest to decode.
module fetch_inst_queue #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 2,
  parameter int DATA_W = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [WIDTH-1:0]                enq_valid,
  input  logic [WIDTH*DATA_W-1:0]         enq_data,
  output logic                            enq_ready,
  output logic [WIDTH-1:0]                deq_valid,
  output logic [WIDTH*DATA_W-1:0]         deq_data,
  input  logic [$clog2(WIDTH+1)-1:0]      deq_count,
  output logic [$clog2(DEPTH+1)-1:0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic              enq_fire;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     n_enq;
  logic [CW-1:0]     n_deq;
  logic [CW-1:0]     deq_req;

  // Readiness uses only registered occupancy, so a full group always fits
  // without relying on whatever decode happens to consume this cycle.
  always_comb begin
    enq_ready = (DEPTH_C - count_q) >= WIDTH_C;
    enq_fire  = enq_ready && (|enq_valid);
    deq_req   = CW'(deq_count);
    n_deq     = (deq_req < count_q) ? deq_req : count_q;
  end

  always_comb begin
    mem_d  = mem_q;
    wr_ptr = tail_q;
    n_enq  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (enq_fire && enq_valid[i]) begin
        mem_d[wr_ptr] = enq_data[i*DATA_W +: DATA_W];
        wr_ptr        = wr_ptr + PW'(1);
        n_enq         = n_enq + CW'(1);
      end
    end
    head_d  = head_q + PW'(n_deq);
    tail_d  = wr_ptr;
    count_d = count_q + n_enq - n_deq;
    // Flush discards everything, including this cycle's enqueue and dequeue.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never cleared; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    deq_valid = '0;
    deq_data  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      deq_valid[i]                 = count_q > CW'(i);
      deq_data[i*DATA_W +: DATA_W] = mem_q[head_q + PW'(i)];
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed and model-based checks of fetch_inst_queue at DEPTH=8, WIDTH=2, DATA_W=64.
module tb_fetch_inst_queue;

  logic         clk;
  logic         reset;
  logic         flush;
  logic [1:0]   enq_valid;
  logic [127:0] enq_data;
  logic         enq_ready;
  logic [1:0]   deq_valid;
  logic [127:0] deq_data;
  logic [1:0]   deq_count;
  logic [3:0]   count;

  int checks = 0;
  int errors = 0;

  fetch_inst_queue #(.DEPTH(8), .WIDTH(2), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_data(deq_data), .deq_count(deq_count),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int t);
    return 64'h0123_4567_0000_0000 | 64'(t);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic enq2(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1);
    enq_valid = v;
    enq_data  = {d1, d0};
    cycle();
    enq_valid = 2'b00;
  endtask

  task automatic deq(input logic [1:0] n);
    deq_count = n;
    cycle();
    deq_count = 2'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", enq_ready); end
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_deq_valid got %b want 00", deq_valid); end
  endtask

  task automatic test_enq_pair();
    enq2(2'b11, 64'hAAAA, 64'hBBBB);
    checks++; if (count !== 4'd2) begin errors++; $display("[TB] FAIL pair_count got %0d want 2", count); end
    checks++; if (deq_valid !== 2'b11) begin errors++; $display("[TB] FAIL pair_valid got %b want 11", deq_valid); end
    checks++; if (deq_data !== {64'hBBBB, 64'hAAAA}) begin errors++; $display("[TB] FAIL pair_data got %h want %h", deq_data, {64'hBBBB, 64'hAAAA}); end
    deq(2'd2);
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL pair_drain got %0d want 0", count); end
  endtask

  task automatic test_compaction();
    enq2(2'b10, 64'h5858, 64'h5959);
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL compact_count got %0d want 1", count); end
    checks++; if (deq_valid !== 2'b01) begin errors++; $display("[TB] FAIL compact_valid got %b want 01", deq_valid); end
    checks++; if (deq_data[63:0] !== 64'h5959) begin errors++; $display("[TB] FAIL compact_slot0 got %h want %h", deq_data[63:0], 64'h5959); end
    deq(2'd1);
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL compact_drain got %0d want 0", count); end
  endtask

  task automatic test_full();
    enq2(2'b11, mk(10), mk(11));
    enq2(2'b11, mk(12), mk(13));
    enq2(2'b11, mk(14), mk(15));
    checks++; if (count !== 4'd6) begin errors++; $display("[TB] FAIL full_count6 got %0d want 6", count); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready6 got %b want 1", enq_ready); end
    enq2(2'b01, mk(16), mk(99));
    checks++; if (count !== 4'd7) begin errors++; $display("[TB] FAIL full_count7 got %0d want 7", count); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready7 got %b want 0", enq_ready); end
    enq2(2'b11, mk(90), mk(91));
    checks++; if (count !== 4'd7) begin errors++; $display("[TB] FAIL full_ignored got %0d want 7", count); end
    checks++; if (deq_data[63:0] !== mk(10)) begin errors++; $display("[TB] FAIL full_head got %h want %h", deq_data[63:0], mk(10)); end
    enq_valid = 2'b11;
    enq_data  = {mk(93), mk(92)};
    deq(2'd2);
    enq_valid = 2'b00;
    checks++; if (count !== 4'd5) begin errors++; $display("[TB] FAIL full_deq_count got %0d want 5", count); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_deq_ready got %b want 1", enq_ready); end
    checks++; if (deq_data !== {mk(13), mk(12)}) begin errors++; $display("[TB] FAIL full_deq_data got %h want %h", deq_data, {mk(13), mk(12)}); end
    deq(2'd2);
    deq(2'd2);
    checks++; if (deq_data[63:0] !== mk(16)) begin errors++; $display("[TB] FAIL full_last got %h want %h", deq_data[63:0], mk(16)); end
    deq(2'd2);
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL full_drain got %0d want 0", count); end
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("[TB] FAIL full_drain_valid got %b want 00", deq_valid); end
  endtask

  task automatic test_wrap();
    enq2(2'b11, mk(20), mk(21));
    enq2(2'b11, mk(22), mk(23));
    enq2(2'b11, mk(24), mk(25));
    deq(2'd2);
    deq(2'd2);
    deq(2'd1);
    checks++; if (count !== 4'd1) begin errors++; $display("[TB] FAIL wrap_pre_count got %0d want 1", count); end
    checks++; if (deq_data[63:0] !== mk(25)) begin errors++; $display("[TB] FAIL wrap_pre_head got %h want %h", deq_data[63:0], mk(25)); end
    enq_valid = 2'b11;
    enq_data  = {mk(31), mk(30)};
    deq(2'd2);
    enq_valid = 2'b00;
    checks++; if (count !== 4'd2) begin errors++; $display("[TB] FAIL wrap_count got %0d want 2", count); end
    checks++; if (deq_valid !== 2'b11) begin errors++; $display("[TB] FAIL wrap_valid got %b want 11", deq_valid); end
    checks++; if (deq_data !== {mk(31), mk(30)}) begin errors++; $display("[TB] FAIL wrap_data got %h want %h", deq_data, {mk(31), mk(30)}); end
    deq(2'd2);
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL wrap_drain got %0d want 0", count); end
  endtask

  task automatic test_flush();
    enq2(2'b11, mk(40), mk(41));
    enq2(2'b11, mk(42), mk(43));
    enq2(2'b11, mk(44), mk(45));
    checks++; if (count !== 4'd6) begin errors++; $display("[TB] FAIL flush_pre got %0d want 6", count); end
    flush     = 1'b1;
    enq_valid = 2'b11;
    enq_data  = {mk(47), mk(46)};
    deq(2'd1);
    flush     = 1'b0;
    enq_valid = 2'b00;
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL flush_count got %0d want 0", count); end
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("[TB] FAIL flush_valid got %b want 00", deq_valid); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready got %b want 1", enq_ready); end
    enq2(2'b11, mk(50), mk(51));
    checks++; if (deq_data !== {mk(51), mk(50)}) begin errors++; $display("[TB] FAIL flush_refill got %h want %h", deq_data, {mk(51), mk(50)}); end
    deq(2'd2);
  endtask

  task automatic test_reset_mid();
    enq2(2'b11, mk(60), mk(61));
    reset     = 1'b1;
    enq_valid = 2'b11;
    enq_data  = {mk(63), mk(62)};
    cycle();
    reset     = 1'b0;
    enq_valid = 2'b00;
    checks++; if (count !== 4'd0) begin errors++; $display("[TB] FAIL midreset_count got %0d want 0", count); end
    checks++; if (deq_valid !== 2'b00) begin errors++; $display("[TB] FAIL midreset_valid got %b want 00", deq_valid); end
  endtask

  task automatic test_random();
    logic [63:0] model_q[$];
    logic        exp_ready;
    int          n_deq;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      exp_ready = (8 - model_q.size()) >= 2;
      checks++; if (count !== 4'(model_q.size())) begin errors++; $display("[TB] FAIL rand_count cyc %0d got %0d want %0d", cyc, count, model_q.size()); end
      checks++; if (enq_ready !== exp_ready) begin errors++; $display("[TB] FAIL rand_ready cyc %0d got %b want %b", cyc, enq_ready, exp_ready); end
      for (int i = 0; i < 2; i++) begin
        checks++; if (deq_valid[i] !== (model_q.size() > i)) begin errors++; $display("[TB] FAIL rand_valid%0d cyc %0d got %b want %b", i, cyc, deq_valid[i], model_q.size() > i); end
        if (model_q.size() > i) begin
          checks++; if (deq_data[i*64 +: 64] !== model_q[i]) begin errors++; $display("[TB] FAIL rand_data%0d cyc %0d got %h want %h", i, cyc, deq_data[i*64 +: 64], model_q[i]); end
        end
      end
      enq_valid = 2'($urandom_range(0, 3));
      enq_data  = {$urandom, $urandom, $urandom, $urandom};
      deq_count = 2'($urandom_range(0, 2));
      flush     = ($urandom_range(0, 31) == 0);
      if (flush) begin
        model_q.delete();
      end else begin
        n_deq = (int'(deq_count) < model_q.size()) ? int'(deq_count) : model_q.size();
        for (int k = 0; k < n_deq; k++) void'(model_q.pop_front());
        if (exp_ready) begin
          if (enq_valid[0]) model_q.push_back(enq_data[63:0]);
          if (enq_valid[1]) model_q.push_back(enq_data[127:64]);
        end
      end
      cycle();
    end
    enq_valid = 2'b00;
    deq_count = 2'd0;
    flush     = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    enq_valid = 2'b00;
    enq_data  = '0;
    deq_count = 2'd0;
    test_reset();
    test_enq_pair();
    test_compaction();
    test_full();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
